// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_pkg: shared types and default widths for the CPU run controller.
//   run_state_t : controller FSM states (IDLE, HOLD, RUN, DONE, TOUT)
//   DEF_*       : default parameter values used by the controller and its interface
//   cnt_width() : bits needed to hold the values 0..max_val (at least 1)
package cpu_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_TOUT = 3'd4
    } run_state_t;

    localparam int unsigned DEF_PC_W             = 8;
    localparam int unsigned DEF_CNT_W            = 16;
    localparam int unsigned DEF_RESET_CYCLES     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 30;
    localparam int unsigned DEF_SELF_LOOP_CYCLES = 3;
    localparam int unsigned DEF_TRACE_DEPTH      = 8;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: link between the run controller and the core it drives.
//   halt_i    : halt strobe from the core
//   pc_i      : core program counter
//   dut_reset : active-high reset driven into the core
// Modports: master = run controller side, slave = core side.
interface cpu_run_controller_if
    import cpu_run_pkg::*;
#(
    parameter int unsigned PC_W = DEF_PC_W
);

    logic            halt_i;
    logic [PC_W-1:0] pc_i;
    logic            dut_reset;

    modport master (
        input  halt_i,
        input  pc_i,
        output dut_reset
    );

    modport slave (
        output halt_i,
        output pc_i,
        input  dut_reset
    );

endinterface

// File: rtl/cpu_run_controller_trace.sv
// pc_trace_buf: circular PC trace buffer for the run controller.
//   clk, reset : clock and synchronous active-high reset
//   i_clear    : empty the buffer (pointer and count to zero)
//   i_wr_en    : append i_wr_data, overwriting the oldest entry once full
//   i_rd_idx   : 0 = most recent entry
//   o_rd_data  : entry at i_rd_idx, registered (one cycle latency)
//   o_count    : number of valid entries, saturates at DEPTH
module pc_trace_buf
    import cpu_run_pkg::*;
#(
    parameter  int unsigned PC_W  = DEF_PC_W,
    parameter  int unsigned DEPTH = DEF_TRACE_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [PC_W-1:0]  i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [PC_W-1:0]  o_rd_data,
    output logic [IDX_W:0]   o_count
);

    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(DEPTH);

    logic [PC_W-1:0]  r_mem [DEPTH];
    logic [IDX_W-1:0] r_wr_ptr;
    logic [IDX_W:0]   r_count;
    logic [PC_W-1:0]  r_rd_data;
    logic [IDX_W-1:0] w_rd_addr;

    // DEPTH is a power of two, so pointer arithmetic wraps around the ring
    assign w_rd_addr = r_wr_ptr - IDX_W'(1) - i_rd_idx;

    // Storage carries no reset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_addr];
            if (i_clear) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + IDX_W'(1);
                if (r_count != FULL) begin
                    r_count <= r_count + (IDX_W + 1)'(1);
                end
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_count   = r_count;

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences the core's reset, counts RUN cycles, detects
// program end (halt strobe or PC self-loop) and enforces a watchdog timeout.
//   clk, reset  : clock, synchronous active-high reset
//   start       : launch/relaunch request, honoured in IDLE/DONE/TOUT only
//   core        : master side of cpu_run_controller_if (halt_i, pc_i, dut_reset)
//   running     : high in RUN
//   done        : high in DONE (program ended)
//   timeout     : high in TOUT (watchdog expired)
//   cycle_count : RUN cycles executed in current/last run
//   last_pc     : pc_i captured on the last RUN cycle
//   trace_idx   : trace read index, 0 = most recent PC
//   trace_data  : trace entry, valid one cycle after trace_idx
//   trace_count : valid trace entries, saturates at TRACE_DEPTH
// Build option: define CPU_RUN_TRACE_EN to include the PC trace buffer;
// otherwise trace_data and trace_count read as zero.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter  int unsigned PC_W             = DEF_PC_W,
    parameter  int unsigned CNT_W            = DEF_CNT_W,
    parameter  int unsigned RESET_CYCLES     = DEF_RESET_CYCLES,
    parameter  int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter  int unsigned SELF_LOOP_CYCLES = DEF_SELF_LOOP_CYCLES,
    parameter  int unsigned TRACE_DEPTH      = DEF_TRACE_DEPTH,
    localparam int unsigned IDX_W            = $clog2(TRACE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    cpu_run_controller_if.master core,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [PC_W-1:0]      last_pc,
    input  logic [IDX_W-1:0]     trace_idx,
    output logic [PC_W-1:0]      trace_data,
    output logic [IDX_W:0]       trace_count
);

    localparam int unsigned HOLD_W  = cnt_width(RESET_CYCLES);
    localparam int unsigned STALL_W = cnt_width(SELF_LOOP_CYCLES);

    run_state_t         r_state, w_state_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [STALL_W-1:0] r_stall_cnt, w_stall_nxt;
    logic [CNT_W-1:0]   r_cycle_cnt, w_cycle_inc;
    logic [PC_W-1:0]    r_last_pc;
    logic               r_dut_reset, r_running, r_done, r_timeout;
    logic               w_enter_hold, w_self_loop, w_timeout_hit;

    // RUN-cycle datapath decisions
    always_comb begin
        w_cycle_inc = r_cycle_cnt + CNT_W'(1);
        // The first RUN cycle compares against a stale last_pc, so it never counts
        if ((r_cycle_cnt != '0) && (core.pc_i == r_last_pc)) begin
            w_stall_nxt = r_stall_cnt + STALL_W'(1);
        end else begin
            w_stall_nxt = '0;
        end
        w_self_loop   = (SELF_LOOP_CYCLES != 0) &&
                        (w_stall_nxt == STALL_W'(SELF_LOOP_CYCLES));
        w_timeout_hit = (w_cycle_inc == CNT_W'(TIMEOUT_CYCLES));
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_hold = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) begin
                    w_state_nxt  = S_HOLD;
                    w_enter_hold = 1'b1;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A halt wins over a watchdog expiry in the same cycle
                if (core.halt_i || w_self_loop) begin
                    w_state_nxt = S_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_TOUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_stall_cnt <= '0;
            r_cycle_cnt <= '0;
            r_last_pc   <= '0;
            r_dut_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Flags are registered from the next state so they track r_state exactly
            r_dut_reset <= (w_state_nxt != S_RUN);
            r_running   <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_DONE);
            r_timeout   <= (w_state_nxt == S_TOUT);
            if (w_enter_hold) begin
                r_hold_cnt  <= '0;
                r_stall_cnt <= '0;
                r_cycle_cnt <= '0;
            end else if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            if (r_state == S_RUN) begin
                r_cycle_cnt <= w_cycle_inc;
                r_stall_cnt <= w_stall_nxt;
                r_last_pc   <= core.pc_i;
            end
        end
    end

    assign core.dut_reset = r_dut_reset;
    assign running        = r_running;
    assign done           = r_done;
    assign timeout        = r_timeout;
    assign cycle_count    = r_cycle_cnt;
    assign last_pc        = r_last_pc;

`ifdef CPU_RUN_TRACE_EN
    logic w_trace_we;
    assign w_trace_we = (r_state == S_RUN);

    pc_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_enter_hold),
        .i_wr_en   (w_trace_we),
        .i_wr_data (core.pc_i),
        .i_rd_idx  (trace_idx),
        .o_rd_data (trace_data),
        .o_count   (trace_count)
    );
`else
    logic w_unused_trace_idx;
    assign w_unused_trace_idx = ^trace_idx;
    assign trace_data  = '0;
    assign trace_count = '0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed runs checked every cycle against a
// queue-based model of the run rules, plus hand-computed literal checks.
module tb_cpu_run_controller;

    localparam int PC_W = 8, CNT_W = 16, RST_CYC = 4, TMO = 30, SLC = 3, DEPTH = 8, IDX_W = 3;
    localparam int PH_IDLE = 0, PH_HOLD = 1, PH_RUN = 2, PH_DONE = 3, PH_TOUT = 4;
`ifdef CPU_RUN_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, start;
    logic              running, done, timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [PC_W-1:0]   last_pc, trace_data;
    logic [IDX_W-1:0]  trace_idx;
    logic [IDX_W:0]    trace_count;

    cpu_run_controller_if #(.PC_W(PC_W)) core_if ();

    cpu_run_controller #(
        .PC_W             (PC_W),
        .CNT_W            (CNT_W),
        .RESET_CYCLES     (RST_CYC),
        .TIMEOUT_CYCLES   (TMO),
        .SELF_LOOP_CYCLES (SLC),
        .TRACE_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core        (core_if),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .last_pc     (last_pc),
        .trace_idx   (trace_idx),
        .trace_data  (trace_data),
        .trace_count (trace_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase, per-run PC history and last-DEPTH PC trace
    int              m_ph;
    int              m_hold_left;
    logic [PC_W-1:0] m_runq[$];
    logic [PC_W-1:0] m_trq[$];
    logic [PC_W-1:0] m_last_pc;
    logic [PC_W-1:0] m_td;
    bit              m_td_ok;
    bit              m_valid = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_ph = PH_IDLE;
            m_runq.delete();
            m_trq.delete();
            m_last_pc = '0;
            m_td = '0;
            m_td_ok = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (TRACE_ON) begin
                m_td_ok = int'(trace_idx) < m_trq.size();
                if (m_td_ok) m_td = m_trq[m_trq.size() - 1 - int'(trace_idx)];
            end else begin
                m_td_ok = 1'b1;
                m_td = '0;
            end
            case (m_ph)
                PH_IDLE, PH_DONE, PH_TOUT: begin
                    if (start) begin
                        m_ph = PH_HOLD;
                        m_hold_left = RST_CYC;
                        m_runq.delete();
                        m_trq.delete();
                    end
                end
                PH_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_ph = PH_RUN;
                end
                PH_RUN: begin
                    bit loop;
                    int n;
                    m_runq.push_back(core_if.pc_i);
                    m_last_pc = core_if.pc_i;
                    m_trq.push_back(core_if.pc_i);
                    if (m_trq.size() > DEPTH) void'(m_trq.pop_front());
                    n = m_runq.size();
                    loop = (SLC > 0) && (n >= SLC + 1);
                    if (loop) begin
                        for (int i = 1; i <= SLC; i++) begin
                            if (m_runq[n - 1 - i] != core_if.pc_i) loop = 1'b0;
                        end
                    end
                    if (core_if.halt_i || loop) m_ph = PH_DONE;
                    else if (n == TMO)          m_ph = PH_TOUT;
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("flags", {core_if.dut_reset, running, done, timeout},
                  {m_ph != PH_RUN, m_ph == PH_RUN, m_ph == PH_DONE, m_ph == PH_TOUT});
            check("cycle_count", cycle_count, m_runq.size());
            check("last_pc", last_pc, m_last_pc);
            check("trace_count", trace_count, TRACE_ON ? m_trq.size() : 0);
            if (m_td_ok) check("trace_data", trace_data, m_td);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit keep_start, output int hc);
        start = 1'b1;
        step();
        start = keep_start;
        hc = 0;
        while (!running && hc < 20) begin
            hc++;
            step();
        end
        check("launch_running", running, 1);
    endtask

    // Drive RUN cycles k=1..max_k: pc=k-1 (or fix_pc from cycle fix_from on)
    task automatic run(input int max_k, input int halt_at, input int fix_from,
                       input logic [PC_W-1:0] fix_pc, input int start_until,
                       input int reset_at, output int ran);
        ran = 0;
        for (int k = 1; k <= max_k; k++) begin
            core_if.pc_i   = (fix_from > 0 && k >= fix_from) ? fix_pc : PC_W'(k - 1);
            core_if.halt_i = (k == halt_at);
            start          = (k <= start_until);
            reset          = (k == reset_at);
            ran = k;
            step();
            if (!running) break;
        end
        core_if.halt_i = 1'b0;
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int hc, ran;
        reset = 1'b1;
        start = 1'b0;
        core_if.halt_i = 1'b0;
        core_if.pc_i = '0;
        trace_idx = '0;

        // 1: reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_dut_reset", core_if.dut_reset, 1);
        check("t1_flags", {running, done, timeout}, 0);
        check("t1_count", cycle_count, 0);
        reset = 1'b0;

        // 2: halt strobe on RUN cycle 10, start held high into RUN (ignored)
        launch(1'b1, hc);
        check("t2_hold_cycles", hc, 4);
        run(20, 10, 0, 8'h00, 5, 0, ran);
        @(negedge clk);
        check("t2_run_cycles", ran, 10);
        check("t2_flags", {done, timeout, running, core_if.dut_reset}, 4'b1001);
        check("t2_count", cycle_count, 10);

        // 3: PC self-loop at 8'h12 from RUN cycle 5
        launch(1'b0, hc);
        run(20, 0, 5, 8'h12, 0, 0, ran);
        @(negedge clk);
        check("t3_flags", {done, timeout, running, core_if.dut_reset}, 4'b1001);
        check("t3_count", cycle_count, 8);
        check("t3_last_pc", last_pc, 8'h12);

        // 4a: incrementing PC never halts -> watchdog
        launch(1'b0, hc);
        run(40, 0, 0, 8'h00, 0, 0, ran);
        @(negedge clk);
        check("t4a_flags", {done, timeout, running, core_if.dut_reset}, 4'b0101);
        check("t4a_count", cycle_count, 30);
        check("t4a_last_pc", last_pc, 8'h1d);

        // 4b: halt on the timeout cycle -> done wins
        launch(1'b0, hc);
        run(40, 30, 0, 8'h00, 0, 0, ran);
        @(negedge clk);
        check("t4b_flags", {done, timeout, running, core_if.dut_reset}, 4'b1001);
        check("t4b_count", cycle_count, 30);

        // 5: reset in RUN cycle 6 aborts, then a normal run
        launch(1'b0, hc);
        run(20, 0, 0, 8'h00, 0, 6, ran);
        @(negedge clk);
        check("t5_abort_cycle", ran, 6);
        check("t5_flags", {done, timeout, running, core_if.dut_reset}, 4'b0001);
        check("t5_count", cycle_count, 0);
        check("t5_last_pc", last_pc, 0);
        launch(1'b0, hc);
        run(20, 5, 0, 8'h00, 0, 0, ran);
        @(negedge clk);
        check("t5_rerun_done", done, 1);
        check("t5_rerun_count", cycle_count, 5);
        check("t5_rerun_last_pc", last_pc, 8'h04);

        // 6: 12 RUN cycles with pc=0..11, then read back the trace
        launch(1'b0, hc);
        run(20, 12, 0, 8'h00, 0, 0, ran);
        @(negedge clk);
        check("t6_count", cycle_count, 12);
        check("t6_trace_count", trace_count, TRACE_ON ? 8 : 0);
        trace_idx = 3'd0;
        step();
        @(negedge clk);
        check("t6_idx0", trace_data, TRACE_ON ? 8'h0b : 8'h00);
        trace_idx = 3'd7;
        step();
        @(negedge clk);
        check("t6_idx7", trace_data, TRACE_ON ? 8'h04 : 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
